// File: rtl/mips_icache_if.sv
// Fetch-port and refill-port bundle for mips_icache.
// slave: cache side (fetch in, inst out, mem_req/addr out); master: core+memory side.
interface mips_icache_if;
    logic [31:0] inst_addr;
    logic [31:0] inst;
    logic        inst_valid;
    logic        flush;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport slave (
        input  inst_addr, flush, mem_ack, mem_rdata,
        output inst, inst_valid, mem_req, mem_addr
    );

    modport master (
        output inst_addr, flush, mem_ack, mem_rdata,
        input  inst, inst_valid, mem_req, mem_addr
    );
endinterface

// File: rtl/mips_icache.sv
// Direct-mapped read-only instruction cache with sequential line refill.
// Ports: clk, rst_b (async low), bus (mips_icache_if.slave: fetch + refill handshake).
module mips_icache #(
    parameter int LINES = 8,
    parameter int WORDS = 4
) (
    input  logic          clk,
    input  logic          rst_b,
    mips_icache_if.slave  bus
);
    localparam int OFF_W = $clog2(WORDS);
    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = 30 - OFF_W - IDX_W;

    typedef enum logic {IDLE, REFILL} state_t;

    state_t             state_q, state_d;
    logic [LINES-1:0]   valid_q, valid_d;
    logic [IDX_W-1:0]   ridx_q, ridx_d;
    logic [TAG_W-1:0]   rtag_q, rtag_d;
    logic [OFF_W-1:0]   cnt_q, cnt_d;
    logic               squash_q, squash_d;
    logic               req_q, req_d;
    logic [31:0]        addr_q, addr_d;
    logic               data_we;
    logic               tag_we;

    logic [TAG_W-1:0]   tag_mem  [LINES];
    logic [31:0]        data_mem [LINES][WORDS];

    logic [OFF_W-1:0]   a_off;
    logic [IDX_W-1:0]   a_idx;
    logic [TAG_W-1:0]   a_tag;
    logic               hit;
    logic               last;
    logic               unused_ok;

    assign a_off = bus.inst_addr[2 +: OFF_W];
    assign a_idx = bus.inst_addr[2 + OFF_W +: IDX_W];
    assign a_tag = bus.inst_addr[31 -: TAG_W];
    assign unused_ok = &{1'b0, bus.inst_addr[1:0]};

    // Lookup is suppressed during refill so the core stays frozen.
    assign hit = (state_q == IDLE) && valid_q[a_idx]
                 && (tag_mem[a_idx] == a_tag);
    assign last = (cnt_q == OFF_W'(WORDS - 1));

    assign bus.inst       = hit ? data_mem[a_idx][a_off] : '0;
    assign bus.inst_valid = hit;
    assign bus.mem_req    = req_q;
    assign bus.mem_addr   = addr_q;

    always_comb begin
        state_d  = state_q;
        valid_d  = valid_q;
        ridx_d   = ridx_q;
        rtag_d   = rtag_q;
        cnt_d    = cnt_q;
        squash_d = squash_q;
        req_d    = req_q;
        addr_d   = addr_q;
        data_we  = 1'b0;
        tag_we   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.flush) valid_d = '0;
                // Miss uses pre-flush valid bits, so a miss in a flush
                // cycle still refills.
                if (!hit) begin
                    ridx_d  = a_idx;
                    rtag_d  = a_tag;
                    cnt_d   = '0;
                    req_d   = 1'b1;
                    addr_d  = {a_tag, a_idx, {OFF_W{1'b0}}, 2'b00};
                    state_d = REFILL;
                end
            end
            REFILL: begin
                if (bus.flush) begin
                    valid_d  = '0;
                    squash_d = 1'b1;
                end
                if (bus.mem_ack) begin
                    data_we = 1'b1;
                    cnt_d   = cnt_q + OFF_W'(1);
                    addr_d  = addr_q + 32'd4;
                    if (last) begin
                        tag_we   = 1'b1;
                        req_d    = 1'b0;
                        squash_d = 1'b0;
                        state_d  = IDLE;
                        if (!squash_q && !bus.flush) valid_d[ridx_q] = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q  <= IDLE;
            valid_q  <= '0;
            ridx_q   <= '0;
            rtag_q   <= '0;
            cnt_q    <= '0;
            squash_q <= 1'b0;
            req_q    <= 1'b0;
            addr_q   <= '0;
        end else begin
            state_q  <= state_d;
            valid_q  <= valid_d;
            ridx_q   <= ridx_d;
            rtag_q   <= rtag_d;
            cnt_q    <= cnt_d;
            squash_q <= squash_d;
            req_q    <= req_d;
            addr_q   <= addr_d;
        end
    end

    // Storage arrays carry no reset; the valid bits gate them.
    always_ff @(posedge clk) begin
        if (data_we) data_mem[ridx_q][cnt_q] <= bus.mem_rdata;
        if (tag_we)  tag_mem[ridx_q] <= rtag_q;
    end
endmodule

// File: tb/tb_mips_icache.sv
// Directed self-checking bench for mips_icache.
// Backing memory returns {16'hC0DE, addr[15:0]} for each word address.
module tb_mips_icache;
    logic clk;
    logic rst_b;
    int   checks;
    int   passed;

    mips_icache_if bus ();

    mips_icache #(.LINES(8), .WORDS(4)) dut (
        .clk   (clk),
        .rst_b (rst_b),
        .bus   (bus)
    );

    function automatic logic [31:0] memw(input logic [31:0] a);
        return {16'hC0DE, a[15:0]};
    endfunction

    assign bus.mem_rdata = memw(bus.mem_addr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs a zero-wait refill of addr; returns at the first hit cycle.
    task automatic run_fill(input logic [31:0] a);
        bus.inst_addr = a;
        bus.mem_ack   = 1'b1;
        repeat (5) step();
    endtask

    task automatic test_reset();
        checks++;
        if (bus.inst_valid !== 1'b0)
            $display("FAIL reset_valid got %b want 0", bus.inst_valid);
        else passed++;
        checks++;
        if (bus.inst !== 32'h0)
            $display("FAIL reset_inst got %h want 0", bus.inst);
        else passed++;
        checks++;
        if (bus.mem_req !== 1'b0)
            $display("FAIL reset_req got %b want 0", bus.mem_req);
        else passed++;
        checks++;
        if (bus.mem_addr !== 32'h0)
            $display("FAIL reset_addr got %h want 0", bus.mem_addr);
        else passed++;
    endtask

    task automatic test_cold_miss();
        bus.inst_addr = 32'h40;
        bus.mem_ack   = 1'b1;
        #1;
        checks++;
        if (bus.inst_valid !== 1'b0 || bus.mem_req !== 1'b0)
            $display("FAIL cold_c0 got v=%b r=%b want 0 0",
                     bus.inst_valid, bus.mem_req);
        else passed++;
        for (int k = 1; k <= 4; k++) begin
            step();
            checks++;
            if (bus.mem_req !== 1'b1 || bus.inst_valid !== 1'b0 ||
                bus.mem_addr !== 32'h40 + 32'(4 * (k - 1)))
                $display("FAIL cold_c%0d got r=%b v=%b a=%h want 1 0 %h",
                         k, bus.mem_req, bus.inst_valid, bus.mem_addr,
                         32'h40 + 32'(4 * (k - 1)));
            else passed++;
        end
        step();
        checks++;
        if (bus.inst_valid !== 1'b1 || bus.inst !== 32'hC0DE0040)
            $display("FAIL cold_c5 got v=%b i=%h want 1 c0de0040",
                     bus.inst_valid, bus.inst);
        else passed++;
        for (int k = 1; k <= 3; k++) begin
            bus.inst_addr = 32'h40 + 32'(4 * k);
            #1;
            checks++;
            if (bus.inst_valid !== 1'b1 || bus.mem_req !== 1'b0 ||
                bus.inst !== memw(32'h40 + 32'(4 * k)))
                $display("FAIL cold_hit%0d got v=%b r=%b i=%h want 1 0 %h",
                         k, bus.inst_valid, bus.mem_req, bus.inst,
                         memw(32'h40 + 32'(4 * k)));
            else passed++;
            step();
        end
    endtask

    task automatic test_conflict();
        bus.inst_addr = 32'hC0;
        bus.mem_ack   = 1'b1;
        #1;
        checks++;
        if (bus.inst_valid !== 1'b0)
            $display("FAIL conf_miss got %b want 0", bus.inst_valid);
        else passed++;
        for (int k = 1; k <= 4; k++) begin
            step();
            checks++;
            if (bus.mem_addr !== 32'hC0 + 32'(4 * (k - 1)) ||
                bus.mem_req !== 1'b1)
                $display("FAIL conf_addr%0d got r=%b a=%h want 1 %h", k,
                         bus.mem_req, bus.mem_addr, 32'hC0 + 32'(4 * (k - 1)));
            else passed++;
        end
        step();
        checks++;
        if (bus.inst_valid !== 1'b1 || bus.inst !== 32'hC0DE00C0)
            $display("FAIL conf_hit got v=%b i=%h want 1 c0de00c0",
                     bus.inst_valid, bus.inst);
        else passed++;
        bus.inst_addr = 32'h40;
        #1;
        checks++;
        if (bus.inst_valid !== 1'b0)
            $display("FAIL conf_evict got %b want 0", bus.inst_valid);
        else passed++;
        step();
        checks++;
        if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h40)
            $display("FAIL conf_refill got r=%b a=%h want 1 00000040",
                     bus.mem_req, bus.mem_addr);
        else passed++;
        repeat (4) step();
        checks++;
        if (bus.inst_valid !== 1'b1 || bus.inst !== 32'hC0DE0040)
            $display("FAIL conf_back got v=%b i=%h want 1 c0de0040",
                     bus.inst_valid, bus.inst);
        else passed++;
    endtask

    task automatic test_wait_states();
        int acks;
        acks = 0;
        bus.inst_addr = 32'h180;
        bus.mem_ack   = 1'b0;
        for (int c = 1; c <= 11; c++) begin
            step();
            if (c > 1 && (c - 1) % 3 == 2) acks++;
            bus.mem_ack = (c % 3 == 2);
            #1;
            checks++;
            if (bus.mem_req !== 1'b1 || bus.inst_valid !== 1'b0 ||
                bus.mem_addr !== 32'h180 + 32'(4 * acks))
                $display("FAIL wait_c%0d got r=%b v=%b a=%h want 1 0 %h", c,
                         bus.mem_req, bus.inst_valid, bus.mem_addr,
                         32'h180 + 32'(4 * acks));
            else passed++;
        end
        step();
        bus.mem_ack = 1'b0;
        #1;
        checks++;
        if (bus.inst_valid !== 1'b1 || bus.mem_req !== 1'b0 ||
            bus.inst !== 32'hC0DE0180)
            $display("FAIL wait_c12 got v=%b r=%b i=%h want 1 0 c0de0180",
                     bus.inst_valid, bus.mem_req, bus.inst);
        else passed++;
        for (int k = 1; k <= 3; k++) begin
            bus.inst_addr = 32'h180 + 32'(4 * k);
            #1;
            checks++;
            if (bus.inst_valid !== 1'b1 || bus.inst !== memw(bus.inst_addr))
                $display("FAIL wait_word%0d got v=%b i=%h want 1 %h", k,
                         bus.inst_valid, bus.inst, memw(32'h180 + 32'(4 * k)));
            else passed++;
        end
        step();
    endtask

    task automatic test_flush_refill();
        bus.inst_addr = 32'h80;
        bus.mem_ack   = 1'b1;
        step();
        step();
        step();
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        #1;
        checks++;
        if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h8C)
            $display("FAIL flush_last got r=%b a=%h want 1 0000008c",
                     bus.mem_req, bus.mem_addr);
        else passed++;
        step();
        bus.mem_ack = 1'b0;
        #1;
        checks++;
        if (bus.inst_valid !== 1'b0 || bus.mem_req !== 1'b0)
            $display("FAIL flush_squash got v=%b r=%b want 0 0",
                     bus.inst_valid, bus.mem_req);
        else passed++;
        bus.inst_addr = 32'h40;
        #1;
        checks++;
        if (bus.inst_valid !== 1'b0)
            $display("FAIL flush_old got %b want 0", bus.inst_valid);
        else passed++;
        run_fill(32'h40);
        checks++;
        if (bus.inst_valid !== 1'b1 || bus.inst !== 32'hC0DE0040)
            $display("FAIL flush_refill got v=%b i=%h want 1 c0de0040",
                     bus.inst_valid, bus.inst);
        else passed++;
    endtask

    task automatic test_addr_change();
        bus.inst_addr = 32'h100;
        bus.mem_ack   = 1'b1;
        step();
        bus.inst_addr = 32'h200;
        for (int k = 0; k < 4; k++) begin
            #1;
            checks++;
            if (bus.mem_addr !== 32'h100 + 32'(4 * k) ||
                bus.inst_valid !== 1'b0)
                $display("FAIL chg_addr%0d got a=%h v=%b want %h 0", k,
                         bus.mem_addr, bus.inst_valid, 32'h100 + 32'(4 * k));
            else passed++;
            step();
        end
        checks++;
        if (bus.inst_valid !== 1'b0 || bus.mem_req !== 1'b0)
            $display("FAIL chg_remiss got v=%b r=%b want 0 0",
                     bus.inst_valid, bus.mem_req);
        else passed++;
        step();
        checks++;
        if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h200)
            $display("FAIL chg_newreq got r=%b a=%h want 1 00000200",
                     bus.mem_req, bus.mem_addr);
        else passed++;
        repeat (4) step();
        checks++;
        if (bus.inst_valid !== 1'b1 || bus.inst !== 32'hC0DE0200)
            $display("FAIL chg_hit got v=%b i=%h want 1 c0de0200",
                     bus.inst_valid, bus.inst);
        else passed++;
    endtask

    task automatic test_async_reset();
        bus.inst_addr = 32'h300;
        bus.mem_ack   = 1'b0;
        step();
        checks++;
        if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h300)
            $display("FAIL arst_pre got r=%b a=%h want 1 00000300",
                     bus.mem_req, bus.mem_addr);
        else passed++;
        #2;
        rst_b = 1'b0;
        #1;
        checks++;
        if (bus.mem_req !== 1'b0 || bus.mem_addr !== 32'h0)
            $display("FAIL arst_now got r=%b a=%h want 0 0",
                     bus.mem_req, bus.mem_addr);
        else passed++;
        step();
        bus.inst_addr = 32'h0;
        rst_b = 1'b1;
        #1;
        checks++;
        if (bus.inst_valid !== 1'b0 || bus.inst !== 32'h0)
            $display("FAIL arst_a0 got v=%b i=%h want 0 0",
                     bus.inst_valid, bus.inst);
        else passed++;
        bus.inst_addr = 32'h40;
        #1;
        checks++;
        if (bus.inst_valid !== 1'b0)
            $display("FAIL arst_inval got %b want 0", bus.inst_valid);
        else passed++;
    endtask

    initial begin
        checks        = 0;
        passed        = 0;
        rst_b         = 1'b0;
        bus.inst_addr = 32'h0;
        bus.flush     = 1'b0;
        bus.mem_ack   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        rst_b = 1'b1;
        #1;
        test_reset();
        test_cold_miss();
        test_conflict();
        test_wait_states();
        test_flush_refill();
        test_addr_change();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/mips_icache.md
# mips_icache

Direct-mapped, read-only instruction cache between the MIPS core fetch port (`inst_addr` → `inst`) and a slower word-wide backing instruction memory. On a hit it returns the instruction combinationally in the same cycle. On a miss it refills the whole line with a sequential request/acknowledge handshake. It signals instruction validity so that fetch-stall logic can freeze the PC while a refill is in progress.

## Interface
Parameters:
- `LINES`, 8: number of cache lines; power of two, ≥ 2.
- `WORDS`, 4: 32-bit words per line; power of two, ≥ 2.

Ports (clock and reset first):
- `clk`  in  1  clock; all state changes on its rising edge.
- `rst_b`  in  1  reset; asynchronous, active-low.
- `inst_addr`  in  32  fetch byte address from the core; bits [1:0] are ignored.
- `inst`  out  32  instruction word; valid only when `inst_valid`=1, otherwise 32'h0.
- `inst_valid`  out  1  hit indication; the core must hold the PC while this is 0.
- `flush`  in  1  single-cycle pulse; invalidates all lines.
- `mem_req`  out  1  refill request to backing memory (registered).
- `mem_addr`  out  32  word-aligned refill address (registered; bits [1:0]=0).
- `mem_ack`  in  1  backing memory returns `mem_rdata` this cycle for `mem_addr`.
- `mem_rdata`  in  32  refill data word.

## Operation
- **Address split:**
  - word offset: `inst_addr[2 +: log2(WORDS)]`
  - index: the next `log2(LINES)` bits
  - tag: the remaining upper bits. Defaults: offset [3:2], index [6:4], tag [31:7].
- **Storage:**
  - per line: valid bit, tag, and `WORDS`×32 data.
  - data and tag arrays have no reset; only valid bits reset.
- **Hit condition:** state == IDLE && `valid[index]` && `tag[index]` == addr tag. This is combinational from `inst_addr`.
- **FSM states:** IDLE and REFILL.
- **IDLE:**
  - on a miss, latch index and tag and set word counter = 0.
  - set `mem_req`=1 and `mem_addr`={tag, index, 0 offset, 2'b00}.
  - go to REFILL.
- **REFILL:**
  - hold `mem_req` and `mem_addr` stable until `mem_ack`=1 is sampled.
  - on each ack: write `mem_rdata` to `data[latched index][counter]`, increment counter, and advance `mem_addr` by 4.
  - on the ack for word `WORDS`-1: set `mem_req`=0, write the tag, set `valid`=1 (unless squashed), and go to IDLE.
- **Refill order:** always word 0 upward. There is no critical-word-first.
- **Address changes during REFILL:** `inst_addr` changes are ignored. After the refill completes, the current `inst_addr` is looked up afresh and may miss again.
- **Stray ack:** `mem_ack` while `mem_req`=0 is ignored.
- **`flush` in IDLE:** all valid bits clear on the next edge, and `inst_valid` drops on the following cycle. A miss detected in the same cycle as `flush` still starts a refill.
- **`flush` in REFILL:** clears all valid bits and sets a squash flag. The refill runs to completion to keep the memory handshake clean, but the refilled line is not marked valid. The squash flag clears on return to IDLE.
- **Reset (any time, including mid-refill):** state = IDLE, all valid bits = 0, `mem_req`=0, `mem_addr`=0, counter = 0, squash = 0.

## Timing
- **Reset values of outputs:** `inst_valid`=0, `inst`=0, `mem_req`=0, `mem_addr`=0.
- **Hit latency:** 0 cycles (combinational `inst`/`inst_valid`).
- **Miss timeline:**
  - miss seen in cycle 0.
  - `mem_req` is high from cycle 1.
  - with `mem_ack` tied high, words are captured at the ends of cycles 1..`WORDS`.
  - the line is valid and hits in cycle `WORDS`+1 (cycle 5 at the defaults).
- **Wait states:** each memory wait cycle adds exactly one cycle.
- **REFILL output:** `inst_valid`=0 throughout REFILL, even if the current address would match a valid line.

## Test plan
- **Reset:** assert `rst_b`=0 mid-refill with `mem_req`=1 → `mem_req`=0 and `mem_addr`=0 immediately (asynchronously). After release, `inst_valid`=0 at address 0x0.
- **Cold miss, zero-wait memory:** `inst_addr`=0x40 with `mem_ack`=1 constantly →
  - `mem_addr`=0x40, 0x44, 0x48, 0x4C in cycles 1–4.
  - cycle 5: `inst_valid`=1 with `inst`=word@0x40.
  - addresses 0x44, 0x48, 0x4C then hit with `mem_req`=0.
- **Conflict:** fill 0x40, then fetch 0xC0 (same index 4, different tag) → refill of 0xC0–0xCC. A return to 0x40 misses again and refills.
- **Wait states:** `mem_ack` pulsed every 3rd cycle → `mem_addr` held stable between acks, each word is captured only on an ack, and the line is valid 12 cycles after the miss.
- **Flush mid-refill:** pulse `flush` after the 2nd ack of the 0x80 refill → all 4 words are still requested. After completion 0x80 misses again, and previously valid lines also miss.
- **Refill-time address change:** change `inst_addr` from 0x100 to 0x200 during the 0x100 refill → refill addresses stay 0x100–0x10C, followed immediately by a miss and refill at 0x200.
